// File: rtl/i2c_slave_regif.sv
// I2C target with 7-bit address and 8-bit register pointer, mapped onto a
// parallel register bus. Oversampled SCL/SDA; no clock stretching.
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         ADDR_INC   = 1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic [7:0] o_reg_addr,
    output logic       o_reg_wr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_rd,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy
);

    localparam logic [7:0] PTR_STEP = (ADDR_INC != 0) ? 8'd1 : 8'd0;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT
    } state_t;

    // Pin synchronisers; reset to the idle-bus level so no false edges follow reset.
    logic [2:0] scl_q, sda_q;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], i_scl};
            sda_q <= {sda_q[1:0], i_sda};
        end
    end

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_s     = scl_q[1];
    assign scl_d     = scl_q[2];
    assign sda_s     = sda_q[1];
    assign sda_d     = sda_q[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    state_t     state, state_nxt;
    logic [3:0] bitcnt, bitcnt_nxt;
    logic       ack_on, ack_on_nxt;
    logic       rw, rw_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       sda_r, sda_nxt;
    logic [7:0] reg_addr, reg_addr_nxt;
    logic       reg_wr, reg_wr_nxt;
    logic [7:0] reg_wdata, reg_wdata_nxt;
    logic       reg_rd, reg_rd_nxt;
    logic       rd_pend;
    logic [7:0] rx_byte;

    assign rx_byte = {shreg[6:0], sda_s};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            bitcnt    <= 4'd0;
            ack_on    <= 1'b0;
            rw        <= 1'b0;
            shreg     <= 8'd0;
            sda_r     <= 1'b1;
            reg_addr  <= 8'd0;
            reg_wr    <= 1'b0;
            reg_wdata <= 8'd0;
            reg_rd    <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bitcnt    <= bitcnt_nxt;
            ack_on    <= ack_on_nxt;
            rw        <= rw_nxt;
            shreg     <= shreg_nxt;
            sda_r     <= sda_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wr    <= reg_wr_nxt;
            reg_wdata <= reg_wdata_nxt;
            reg_rd    <= reg_rd_nxt;
            rd_pend   <= reg_rd;
        end
    end

    always_comb begin
        state_nxt     = state;
        bitcnt_nxt    = bitcnt;
        ack_on_nxt    = ack_on;
        rw_nxt        = rw;
        shreg_nxt     = shreg;
        sda_nxt       = sda_r;
        reg_addr_nxt  = reg_addr;
        reg_wr_nxt    = 1'b0;
        reg_wdata_nxt = reg_wdata;
        reg_rd_nxt    = 1'b0;

        // Read data lands one cycle after the strobe, well before the next SCL fall.
        if (rd_pend)
            shreg_nxt = i_reg_rdata;

        if (start_det) begin
            state_nxt  = ST_ADDR;
            bitcnt_nxt = 4'd0;
            ack_on_nxt = 1'b0;
            sda_nxt    = 1'b1;
        end else if (stop_det) begin
            state_nxt  = ST_IDLE;
            bitcnt_nxt = 4'd0;
            ack_on_nxt = 1'b0;
            sda_nxt    = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt  = rx_byte;
                        bitcnt_nxt = bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            bitcnt_nxt = 4'd0;
                            if (state == ST_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw_nxt    = rx_byte[0];
                                    state_nxt = ST_ADDR_ACK;
                                end else begin
                                    state_nxt = ST_WAIT;
                                end
                            end else if (state == ST_REG) begin
                                reg_addr_nxt = rx_byte;
                                state_nxt    = ST_REG_ACK;
                            end else begin
                                reg_wdata_nxt = rx_byte;
                                reg_wr_nxt    = 1'b1;
                                state_nxt     = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall drives the ACK, second fall (after the 9th rise) releases it.
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_nxt    = 1'b0;
                            ack_on_nxt = 1'b1;
                            if (state == ST_ADDR_ACK && rw)
                                reg_rd_nxt = 1'b1;
                        end else begin
                            ack_on_nxt = 1'b0;
                            sda_nxt    = 1'b1;
                            bitcnt_nxt = 4'd0;
                            if (state == ST_ADDR_ACK) begin
                                if (rw) begin
                                    sda_nxt   = shreg[7];
                                    shreg_nxt = {shreg[6:0], 1'b0};
                                    state_nxt = ST_RDATA;
                                end else begin
                                    state_nxt = ST_REG;
                                end
                            end else if (state == ST_REG_ACK) begin
                                state_nxt = ST_WDATA;
                            end else begin
                                reg_addr_nxt = reg_addr + PTR_STEP;
                                state_nxt    = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bitcnt_nxt = bitcnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            sda_nxt    = 1'b1;
                            bitcnt_nxt = 4'd0;
                            state_nxt  = ST_RDATA_ACK;
                        end else begin
                            sda_nxt   = shreg[7];
                            shreg_nxt = {shreg[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            reg_addr_nxt = reg_addr + PTR_STEP;
                            reg_rd_nxt   = 1'b1;
                            bitcnt_nxt   = 4'd0;
                            state_nxt    = ST_RDATA;
                        end else begin
                            sda_nxt   = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda       = sda_r;
    assign o_reg_addr  = reg_addr;
    assign o_reg_wr    = reg_wr;
    assign o_reg_wdata = reg_wdata;
    assign o_reg_rd    = reg_rd;
    assign o_busy      = !(state inside {ST_IDLE, ST_ADDR, ST_WAIT});

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, register-bus scoreboard.
module tb_i2c_slave_regif;

    localparam int Q = 5;
    localparam int H = 10;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       o_sda;
    logic [7:0] o_reg_addr;
    logic       o_reg_wr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_rd;
    logic [7:0] i_reg_rdata = 8'd0;
    logic       o_busy;
    logic       sda_bus;

    assign sda_bus = m_sda & o_sda;

    i2c_slave_regif #(.SLAVE_ADDR(7'h42), .ADDR_INC(1)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_scl(m_scl), .i_sda(sda_bus),
        .o_sda(o_sda), .o_reg_addr(o_reg_addr), .o_reg_wr(o_reg_wr),
        .o_reg_wdata(o_reg_wdata), .o_reg_rd(o_reg_rd),
        .i_reg_rdata(i_reg_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  mem [256];
    logic        sda_low_seen = 1'b0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Register-file model answering read strobes one cycle later.
    always @(posedge i_clk)
        if (o_reg_rd) i_reg_rdata <= mem[o_reg_addr];

    always @(negedge i_clk) begin
        if (!o_sda) sda_low_seen <= 1'b1;
        if (i_rstn && o_reg_wr) begin
            if (wr_q.size() > 0) chk("wr_addr_data", {o_reg_addr, o_reg_wdata}, wr_q.pop_front());
            else                 chk("wr_extra", {15'd0, o_reg_wr}, 16'd0);
        end
        if (i_rstn && o_reg_rd) begin
            if (rd_q.size() > 0) chk("rd_addr", {8'd0, o_reg_addr}, {8'd0, rd_q.pop_front()});
            else                 chk("rd_extra", {15'd0, o_reg_rd}, 16'd0);
        end
    end

    task automatic hw(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hw(Q);
        m_scl = 1'b1; hw(H);
        m_sda = 1'b0; hw(H);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hw(Q);
        m_scl = 1'b1; hw(H);
        m_sda = 1'b1; hw(H);
    endtask

    task automatic wr_bit(input logic b);
        hw(Q); m_sda = b; hw(Q);
        m_scl = 1'b1; hw(H);
        m_scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(b[i]);
        m_sda = 1'b1; hw(2*Q);
        m_scl = 1'b1; hw(H/2);
        ack = !sda_bus; hw(H/2);
        m_scl = 1'b0;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; hw(2*Q);
            m_scl = 1'b1; hw(H/2);
            d[i] = sda_bus; hw(H/2);
            m_scl = 1'b0;
        end
        hw(1); m_sda = nack; hw(2*Q - 1);
        m_scl = 1'b1; hw(H);
        m_scl = 1'b0;
        hw(1); m_sda = 1'b1;
    endtask

    logic       ack;
    logic [7:0] d;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h12] = 8'hA5;

        hw(4);
        chk("rst_sda", {15'd0, o_sda}, 16'd1);
        chk("rst_busy", {15'd0, o_busy}, 16'd0);
        chk("rst_wr", {15'd0, o_reg_wr}, 16'd0);
        chk("rst_rd", {15'd0, o_reg_rd}, 16'd0);
        chk("rst_addr", {8'd0, o_reg_addr}, 16'd0);
        i_rstn = 1'b1; hw(4);

        // single write
        wr_q.push_back({8'h12, 8'h80});
        i2c_start();
        wr_byte(8'h84, ack); chk("t1_ack_addr", {15'd0, ack}, 16'd1);
        chk("t1_busy", {15'd0, o_busy}, 16'd1);
        wr_byte(8'h12, ack); chk("t1_ack_reg", {15'd0, ack}, 16'd1);
        wr_byte(8'h80, ack); chk("t1_ack_data", {15'd0, ack}, 16'd1);
        i2c_stop(); hw(4);
        chk("t1_busy_end", {15'd0, o_busy}, 16'd0);

        // address miss
        sda_low_seen = 1'b0;
        i2c_start();
        wr_byte(8'h86, ack); chk("t2_nack_addr", {15'd0, ack}, 16'd0);
        chk("t2_busy", {15'd0, o_busy}, 16'd0);
        wr_byte(8'h12, ack); chk("t2_nack_reg", {15'd0, ack}, 16'd0);
        i2c_stop(); hw(4);
        chk("t2_sda_never_low", {15'd0, sda_low_seen}, 16'd0);

        // combined read
        rd_q.push_back(8'h12);
        i2c_start();
        wr_byte(8'h84, ack); chk("t3_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h12, ack); chk("t3_ack_reg", {15'd0, ack}, 16'd1);
        i2c_start();
        wr_byte(8'h85, ack); chk("t3_ack_raddr", {15'd0, ack}, 16'd1);
        rd_byte(1'b1, d);   chk("t3_rdata", {8'd0, d}, 16'h00A5);
        i2c_stop(); hw(4);

        // burst write with pointer wrap
        wr_q.push_back({8'hFE, 8'h11});
        wr_q.push_back({8'hFF, 8'h22});
        wr_q.push_back({8'h00, 8'h33});
        i2c_start();
        wr_byte(8'h84, ack); chk("t4_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'hFE, ack); chk("t4_ack_reg", {15'd0, ack}, 16'd1);
        wr_byte(8'h11, ack); chk("t4_ack_d0", {15'd0, ack}, 16'd1);
        wr_byte(8'h22, ack); chk("t4_ack_d1", {15'd0, ack}, 16'd1);
        wr_byte(8'h33, ack); chk("t4_ack_d2", {15'd0, ack}, 16'd1);
        i2c_stop(); hw(4);
        chk("t4_wr_q_drained", 16'(wr_q.size()), 16'd0);

        // burst read: ACK, ACK, NACK
        rd_q.push_back(8'h20); rd_q.push_back(8'h21); rd_q.push_back(8'h22);
        i2c_start();
        wr_byte(8'h84, ack); chk("t5_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h20, ack); chk("t5_ack_reg", {15'd0, ack}, 16'd1);
        i2c_start();
        wr_byte(8'h85, ack); chk("t5_ack_raddr", {15'd0, ack}, 16'd1);
        rd_byte(1'b0, d); chk("t5_rd0", {8'd0, d}, {8'd0, 8'h20 ^ 8'h5A});
        rd_byte(1'b0, d); chk("t5_rd1", {8'd0, d}, {8'd0, 8'h21 ^ 8'h5A});
        rd_byte(1'b1, d); chk("t5_rd2", {8'd0, d}, {8'd0, 8'h22 ^ 8'h5A});
        hw(4);
        chk("t5_busy_after_nack", {15'd0, o_busy}, 16'd0);
        chk("t5_sda_after_nack", {15'd0, o_sda}, 16'd1);
        i2c_stop(); hw(4);
        chk("t5_rd_q_drained", 16'(rd_q.size()), 16'd0);

        // abort: STOP after 4 data bits, no write strobe expected
        i2c_start();
        wr_byte(8'h84, ack); chk("t6_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h30, ack); chk("t6_ack_reg", {15'd0, ack}, 16'd1);
        for (int i = 0; i < 4; i++) wr_bit(1'b1);
        i2c_stop(); hw(4);
        chk("t6_busy_abort", {15'd0, o_busy}, 16'd0);
        chk("t6_ptr", {8'd0, o_reg_addr}, 16'h0030);

        // reset while the target is driving ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) wr_bit(d[0] ? 1'b0 : 1'b0 | 8'h84 >> i);
        m_sda = 1'b1; hw(2*Q);
        m_scl = 1'b1; hw(H/2);
        chk("t6_ack_driven", {15'd0, o_sda}, 16'd0);
        i_rstn = 1'b0; #1;
        chk("t6_rst_sda", {15'd0, o_sda}, 16'd1);
        chk("t6_rst_busy", {15'd0, o_busy}, 16'd0);
        chk("t6_rst_addr", {8'd0, o_reg_addr}, 16'd0);
        hw(H/2); m_scl = 1'b0; hw(H);
        m_scl = 1'b1; hw(H);
        i_rstn = 1'b1; hw(8);

        chk("final_wr_q", 16'(wr_q.size()), 16'd0);
        chk("final_rd_q", 16'(rd_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
